// File: rtl/fm_logo_pkg.sv
// rtl/fm_logo_pkg.sv - shared widths and state encoding for the FM logo fetch block
// Contents:
//   LOGO_ADDR_W / LOGO_DATA_W / LOGO_DEPTH - logo memory geometry
//   logo_state_t                           - fetch FSM state encoding
package fm_logo_pkg;

    localparam int LOGO_ADDR_W = 14;
    localparam int LOGO_DATA_W = 8;
    localparam int LOGO_DEPTH  = 1 << LOGO_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } logo_state_t;

endpackage

// File: rtl/fm_logo_skid.sv
// rtl/fm_logo_skid.sv - two-entry FIFO holding fetched logo bytes ahead of the stream
// Ports:
//   clock, reset        - clock and asynchronous active-high reset
//   push, push_data     - write one byte (ignored when full and not popping)
//   pop                 - consume the head byte (ignored when empty)
//   count               - current occupancy, 0..2
//   out_valid, out_data - head of the FIFO
module fm_logo_skid
    import fm_logo_pkg::*;
#(
    parameter int DATA_W = LOGO_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop & (cnt != 2'd0);
    // A full FIFO can still take a byte in the same cycle its head leaves.
    assign push_ok = push & ((cnt != 2'd2) | pop_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                if (wr_ptr) begin
                    entry1 <= push_data;
                end else begin
                    entry0 <= push_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign count     = cnt;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = rd_ptr ? entry1 : entry0;

endmodule

// File: rtl/fm_logo_fetch.sv
// rtl/fm_logo_fetch.sv - sequential reader streaming a byte range of the FM logo memory
// Ports:
//   clock, reset            - clock and asynchronous active-high reset
//   start, base, len        - range command, sampled only when idle
//   busy, done              - range in progress / one-cycle completion pulse
//   mem_address, mem_wren,
//   mem_data, mem_q         - logo memory port (read-only use, one-cycle latency)
//   out_data, out_valid,
//   out_ready, out_last     - byte stream towards the overlay path
module fm_logo_fetch
    import fm_logo_pkg::*;
#(
    parameter int ADDR_W = LOGO_ADDR_W,
    parameter int DATA_W = LOGO_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logo_state_t       state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   out_cnt;
    logic              inflight;
    logic              busy_r;
    logic              done_r;

    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        load;
    logic              issue;

    assign pop = out_valid & out_ready;

    // Bytes that will still be held after this cycle's pop; a new read is only
    // issued when the buffer can take its data without a stall ever dropping it.
    assign load  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == FETCH) && (issue_cnt != '0) && (load < 3'd2);

    // The address counter is shown on the port only in issue cycles; otherwise
    // the last issued address is held and the returned q is simply not captured.
    assign mem_address = issue ? addr_cnt : addr_hold;
    assign mem_wren    = 1'b0;
    assign mem_data    = '0;

    assign busy     = busy_r;
    assign done     = done_r;
    assign out_last = out_valid & (out_cnt == CNT_ONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            addr_hold <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            inflight  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            inflight <= issue;

            if (issue) begin
                addr_hold <= addr_cnt;
                addr_cnt  <= addr_cnt + ADDR_ONE;
                issue_cnt <= issue_cnt - CNT_ONE;
            end

            if (pop) begin
                out_cnt <= out_cnt - CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            addr_cnt  <= base;
                            issue_cnt <= len;
                            out_cnt   <= len;
                            busy_r    <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue && (issue_cnt == CNT_ONE)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (out_cnt == CNT_ONE)) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fm_logo_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data (mem_q),
        .pop       (pop),
        .count     (occ),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_fm_logo_fetch.sv
// tb/tb_fm_logo_fetch.sv - directed self-checking bench for fm_logo_fetch
module tb_fm_logo_fetch;

    logic        clock;
    logic        reset;
    logic        start;
    logic [13:0] base;
    logic [14:0] len;
    logic        busy;
    logic        done;
    logic [13:0] mem_address;
    logic        mem_wren;
    logic [7:0]  mem_data;
    logic [7:0]  mem_q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [7:0]  logo_mem [16384];

    int n_checks;
    int n_fail;

    fm_logo_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base        (base),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_wren    (mem_wren),
        .mem_data    (mem_data),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) mem_q <= logo_mem[mem_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one range and follow it to completion. rnd selects a pseudo-random
    // out_ready with a forced 10-cycle stall; poke re-pulses start mid-run.
    task automatic run(input logic [13:0] b, input logic [14:0] n, input bit rnd, input bit poke);
        int          got;
        int          cyc;
        int          limit;
        bit          fin;
        bit          stall_prev;
        logic [7:0]  held;
        logic [13:0] ea;
        base      = b;
        len       = n;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        got = 0;
        fin = 0;
        stall_prev = 0;
        held = 8'h00;
        limit = int'(n) + 200;
        check("busy_after_start", busy, 1);
        while (!fin && cyc < limit) begin
            if (rnd) out_ready = (cyc >= 6 && cyc < 16) ? 1'b0 : 1'($urandom_range(0, 1));
            else     out_ready = 1'b1;
            if (poke) begin
                start = (cyc == 3);
                if (cyc == 3) begin
                    base = 14'h2222;
                    len  = 15'd5;
                end
            end
            if (!rnd && n <= 16 && cyc <= int'(n)) begin
                ea = b + 14'(cyc - 1);
                check("mem_address", mem_address, ea);
            end
            if (!rnd) check("valid_timing", out_valid, (cyc >= 3 && cyc <= int'(n) + 2));
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held);
            end
            stall_prev = out_valid && !out_ready;
            held = out_data;
            check("no_early_done", done, 0);
            check("busy_during", busy, 1);
            if (out_valid && out_ready) begin
                ea = b + 14'(got);
                check("data", out_data, ea[7:0]);
                check("last", out_last, (got == int'(n) - 1));
                got++;
            end
            step();
            cyc++;
            if (got == int'(n)) fin = 1;
        end
        start = 1'b0;
        if (!fin) check("timeout_bytes", got, n);
        check("done_pulse", done, 1);
        check("busy_clear", busy, 0);
        check("valid_after", out_valid, 0);
        if (!rnd) check("done_cycle", cyc, int'(n) + 3);
        step();
        check("done_one_cycle", done, 0);
        check("no_extra_byte", out_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        base      = '0;
        len       = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16384; i++) logo_mem[i] = 8'(i);

        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", mem_address, 0);
        check("rst_wren", mem_wren, 0);
        check("rst_mdata", mem_data, 0);
        reset = 1'b0;
        step();

        run(14'h0010, 15'd4, 0, 0);
        run(14'h3FFE, 15'd4, 0, 0);
        run(14'h0123, 15'd16, 1, 0);

        // Zero-length command: done next cycle, nothing else moves.
        base  = 14'h0500;
        len   = 15'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("len0_busy_later", busy, 0);
            check("len0_valid_later", out_valid, 0);
            check("len0_done_later", done, 0);
        end

        run(14'h0200, 15'd8, 0, 1);

        // Reset mid-range after three bytes have been taken.
        base      = 14'h0040;
        len       = 15'd8;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_addr", mem_address, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_done", done, 0);
            check("post_rst_valid", out_valid, 0);
        end
        run(14'h0100, 15'd2, 0, 0);

        run(14'h2000, 15'd16384, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
